// File: rtl/idli_pkg.sv
// Shared types and defaults for the idli slice-serial execute stage.
// Holds the ALU/compare opcode enums and the compare-result selector.
package idli_pkg;

  typedef enum logic [2:0] {
    SX_ALU_ADD = 3'd0,
    SX_ALU_AND = 3'd1,
    SX_ALU_OR  = 3'd2,
    SX_ALU_XOR = 3'd3,
    SX_ALU_CMP = 3'd4
  } sx_alu_op_t;

  typedef enum logic [1:0] {
    SX_CMP_EQ  = 2'd0,
    SX_CMP_NE  = 2'd1,
    SX_CMP_LTU = 2'd2,
    SX_CMP_LT  = 2'd3
  } sx_cmp_t;

  localparam int SX_SLICE_W_DEFAULT    = 4;
  localparam int SX_NUM_SLICES_DEFAULT = 4;

  // Picks the predicate value for a compare from the final-slice flags.
  function automatic logic sx_cmp_sel(
    input sx_cmp_t cmp,
    input logic    eq,
    input logic    ltu,
    input logic    lt
  );
    case (cmp)
      SX_CMP_EQ:  return eq;
      SX_CMP_NE:  return !eq;
      SX_CMP_LTU: return ltu;
      default:    return lt;
    endcase
  endfunction

endpackage

// File: rtl/idli_sx_alu_m.sv
// Combinational single-slice ALU: add/compare plus bitwise ops.
// Bitwise ops pass the incoming carry straight through; the parent owns all state.
module idli_sx_alu_m
  import idli_pkg::*;
#(
  parameter int SLICE_W = SX_SLICE_W_DEFAULT
) (
  input  sx_alu_op_t         i_op,
  input  logic [SLICE_W-1:0] i_lhs,
  input  logic [SLICE_W-1:0] i_rhs,
  input  logic               i_inv,
  input  logic               i_cin,
  output logic [SLICE_W-1:0] o_sum,
  output logic               o_cout,
  output logic               o_zero,
  output logic               o_msb,
  output logic               o_ovf
);

  logic [SLICE_W-1:0] rhs_x;
  logic [SLICE_W:0]   add_full;

  always_comb begin
    rhs_x    = i_inv ? ~i_rhs : i_rhs;
    add_full = {1'b0, i_lhs} + {1'b0, rhs_x} + {{SLICE_W{1'b0}}, i_cin};
    o_sum    = add_full[SLICE_W-1:0];
    o_cout   = add_full[SLICE_W];
    case (i_op)
      SX_ALU_AND: begin o_sum = i_lhs & rhs_x; o_cout = i_cin; end
      SX_ALU_OR:  begin o_sum = i_lhs | rhs_x; o_cout = i_cin; end
      SX_ALU_XOR: begin o_sum = i_lhs ^ rhs_x; o_cout = i_cin; end
      default: ;
    endcase
    o_zero = (o_sum == '0);
    o_msb  = o_sum[SLICE_W-1];
    // Signed overflow only matters for the adder path (used by LT on the last slice).
    o_ovf  = (i_lhs[SLICE_W-1] == rhs_x[SLICE_W-1]) &&
             (add_full[SLICE_W-1] != i_lhs[SLICE_W-1]);
  end

endmodule

// File: rtl/idli_serial_ex_m.sv
// Slice-serial execute unit: one SLICE_W slice per cycle, LSB first, with predication and stall.
// Optional retired/squashed counters are built when IDLI_SX_PERF_CTR_EN is defined.
module idli_serial_ex_m
  import idli_pkg::*;
#(
  parameter  int SLICE_W    = SX_SLICE_W_DEFAULT,
  parameter  int NUM_SLICES = SX_NUM_SLICES_DEFAULT,
  parameter  int NUM_GREGS  = 16,
  parameter  int NUM_PREGS  = 8,
  localparam int GREG_W     = $clog2(NUM_GREGS),
  localparam int PREG_W     = $clog2(NUM_PREGS),
  localparam int CTR_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
) (
  input  logic               i_sx_gck,
  input  logic               i_sx_rst_n,
  input  logic               i_sx_op_vld,
  output logic               o_sx_op_acp,
  input  sx_alu_op_t         i_sx_alu_op,
  input  logic               i_sx_rhs_inv,
  input  logic               i_sx_cin,
  input  sx_cmp_t            i_sx_cmp,
  input  logic [GREG_W-1:0]  i_sx_a,
  input  logic               i_sx_a_vld,
  input  logic [PREG_W-1:0]  i_sx_q,
  input  logic               i_sx_q_vld,
  input  logic               i_sx_pred,
  input  logic               i_sx_stall,
  input  logic [SLICE_W-1:0] i_sx_lhs,
  input  logic [SLICE_W-1:0] i_sx_rhs,
  output logic [CTR_W-1:0]   o_sx_ctr,
  output logic               o_sx_busy,
  output logic               o_sx_wr_en,
  output logic [GREG_W-1:0]  o_sx_wr_reg,
  output logic [SLICE_W-1:0] o_sx_wr_data,
  output logic               o_sx_pwr_en,
  output logic [PREG_W-1:0]  o_sx_pwr,
  output logic               o_sx_pwr_data,
  output logic               o_sx_done
`ifdef IDLI_SX_PERF_CTR_EN
  ,
  output logic [15:0]        o_sx_retired,
  output logic [15:0]        o_sx_squashed
`endif
);

  localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(NUM_SLICES - 1);

  logic             busy_q, busy_d;
  logic [CTR_W-1:0] ctr_q, ctr_d;
  logic             carry_q, carry_d;
  logic             eq_acc_q, eq_acc_d;

  sx_alu_op_t        alu_op_q;
  sx_cmp_t           cmp_q;
  logic              inv_q, cin_q, pred_q;
  logic [GREG_W-1:0] a_q;
  logic              a_vld_q;
  logic [PREG_W-1:0] q_q;
  logic              q_vld_q;

  logic acp, adv, last, first;
  logic slice_cin, eq_in, eq_full;

  logic [SLICE_W-1:0] alu_sum;
  logic               alu_cout, alu_zero, alu_msb, alu_ovf;

  idli_sx_alu_m #(
    .SLICE_W (SLICE_W)
  ) u_alu (
    .i_op   (alu_op_q),
    .i_lhs  (i_sx_lhs),
    .i_rhs  (i_sx_rhs),
    .i_inv  (inv_q),
    .i_cin  (slice_cin),
    .o_sum  (alu_sum),
    .o_cout (alu_cout),
    .o_zero (alu_zero),
    .o_msb  (alu_msb),
    .o_ovf  (alu_ovf)
  );

  always_comb begin
    first     = (ctr_q == '0);
    last      = (ctr_q == CTR_LAST);
    adv       = busy_q && !i_sx_stall;
    // Accepting on the last slice lets the next op start with no bubble.
    acp       = !i_sx_stall && (!busy_q || last);
    slice_cin = first ? cin_q : carry_q;
    eq_in     = first ? 1'b1 : eq_acc_q;
    eq_full   = eq_in && alu_zero;

    busy_d   = busy_q;
    ctr_d    = ctr_q;
    carry_d  = carry_q;
    eq_acc_d = eq_acc_q;
    if (adv) begin
      ctr_d    = ctr_q + CTR_W'(1);
      carry_d  = alu_cout;
      eq_acc_d = eq_full;
    end
    if (acp) begin
      busy_d = i_sx_op_vld;
      ctr_d  = '0;
    end
  end

  always_ff @(posedge i_sx_gck) begin
    if (!i_sx_rst_n) begin
      busy_q   <= 1'b0;
      ctr_q    <= '0;
      carry_q  <= 1'b0;
      eq_acc_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      ctr_q    <= ctr_d;
      carry_q  <= carry_d;
      eq_acc_q <= eq_acc_d;
    end
  end

  // Op fields are only meaningful while busy, so they need no reset.
  always_ff @(posedge i_sx_gck) begin
    if (acp) begin
      alu_op_q <= i_sx_alu_op;
      cmp_q    <= i_sx_cmp;
      inv_q    <= i_sx_rhs_inv;
      cin_q    <= i_sx_cin;
      pred_q   <= i_sx_pred;
      a_q      <= i_sx_a;
      a_vld_q  <= i_sx_a_vld;
      q_q      <= i_sx_q;
      q_vld_q  <= i_sx_q_vld;
    end
  end

  always_comb begin
    o_sx_op_acp   = acp;
    o_sx_busy     = busy_q;
    o_sx_ctr      = ctr_q;
    o_sx_done     = adv && last;
    o_sx_wr_en    = adv && pred_q && a_vld_q && (alu_op_q != SX_ALU_CMP);
    o_sx_wr_reg   = a_q;
    o_sx_wr_data  = alu_sum;
    o_sx_pwr_en   = adv && last && pred_q && q_vld_q;
    o_sx_pwr      = q_q;
    o_sx_pwr_data = (alu_op_q == SX_ALU_CMP)
                  ? sx_cmp_sel(cmp_q, eq_full, !alu_cout, alu_msb ^ alu_ovf)
                  : alu_zero;
  end

`ifdef IDLI_SX_PERF_CTR_EN
  logic [15:0] retired_q, squashed_q;

  always_ff @(posedge i_sx_gck) begin
    if (!i_sx_rst_n) begin
      retired_q  <= '0;
      squashed_q <= '0;
    end else if (adv && last) begin
      if (pred_q) retired_q  <= retired_q + 16'd1;
      else        squashed_q <= squashed_q + 16'd1;
    end
  end

  assign o_sx_retired  = retired_q;
  assign o_sx_squashed = squashed_q;
`endif

endmodule

// File: tb/tb_idli_serial_ex_m.sv
// Directed self-checking bench for idli_serial_ex_m (4 slices of 4 bits).
// Acts as the GPR read port: feeds the operand slice selected by the DUT counter.
module tb_idli_serial_ex_m;
  import idli_pkg::*;

  logic gck = 1'b0;
  always #5 gck = ~gck;

  logic       rst_n, op_vld, rhs_inv, cin, a_vld, q_vld, pred, stall;
  sx_alu_op_t alu_op;
  sx_cmp_t    cmp;
  logic [3:0] a, lhs, rhs;
  logic [2:0] q;

  logic       acp_o, busy_o, wr_en_o, pwr_en_o, pwr_data_o, done_o;
  logic [1:0] ctr_o;
  logic [3:0] wr_reg_o, wr_data_o;
  logic [2:0] pwr_o;
`ifdef IDLI_SX_PERF_CTR_EN
  logic [15:0] retired_o, squashed_o;
`endif

  idli_serial_ex_m dut (
    .i_sx_gck      (gck),
    .i_sx_rst_n    (rst_n),
    .i_sx_op_vld   (op_vld),
    .o_sx_op_acp   (acp_o),
    .i_sx_alu_op   (alu_op),
    .i_sx_rhs_inv  (rhs_inv),
    .i_sx_cin      (cin),
    .i_sx_cmp      (cmp),
    .i_sx_a        (a),
    .i_sx_a_vld    (a_vld),
    .i_sx_q        (q),
    .i_sx_q_vld    (q_vld),
    .i_sx_pred     (pred),
    .i_sx_stall    (stall),
    .i_sx_lhs      (lhs),
    .i_sx_rhs      (rhs),
    .o_sx_ctr      (ctr_o),
    .o_sx_busy     (busy_o),
    .o_sx_wr_en    (wr_en_o),
    .o_sx_wr_reg   (wr_reg_o),
    .o_sx_wr_data  (wr_data_o),
    .o_sx_pwr_en   (pwr_en_o),
    .o_sx_pwr      (pwr_o),
    .o_sx_pwr_data (pwr_data_o),
    .o_sx_done     (done_o)
`ifdef IDLI_SX_PERF_CTR_EN
    ,
    .o_sx_retired  (retired_o),
    .o_sx_squashed (squashed_o)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Values applied to the DUT at the next negedge.
  logic        n_rst = 1'b0, n_vld = 1'b0, n_inv = 1'b0, n_cin = 1'b0;
  logic        n_avld = 1'b0, n_qvld = 1'b0, n_pred = 1'b1, n_stall = 1'b0;
  sx_alu_op_t  n_op = SX_ALU_ADD;
  sx_cmp_t     n_cmp = SX_CMP_EQ;
  logic [3:0]  n_a = '0;
  logic [2:0]  n_q = '0;
  logic [15:0] lhs_v = '0, rhs_v = '0;

  int         cnum = 0;
  logic       s_acp, s_busy, s_done, s_wr, s_pwr;
  logic [1:0] s_ctr;
  logic [3:0] wr_dat[$];
  logic [3:0] wr_reg[$];
  int         wr_cyc[$];
  logic       pwr_dat[$];
  logic [2:0] pwr_reg[$];
  logic [1:0] pwr_ctr[$];
  int         ndone, done_cyc;
  logic [1:0] done_ctr;

  task automatic cyc();
    @(negedge gck);
    rst_n   = n_rst;   op_vld = n_vld;  alu_op = n_op;   rhs_inv = n_inv;
    cin     = n_cin;   cmp    = n_cmp;  a      = n_a;    a_vld   = n_avld;
    q       = n_q;     q_vld  = n_qvld; pred   = n_pred; stall   = n_stall;
    lhs     = 4'(lhs_v >> (4 * ctr_o));
    rhs     = 4'(rhs_v >> (4 * ctr_o));
    #1;
    cnum++;
    s_acp = acp_o; s_busy = busy_o; s_ctr = ctr_o; s_done = done_o;
    s_wr  = wr_en_o; s_pwr = pwr_en_o;
    if (wr_en_o === 1'b1) begin
      wr_dat.push_back(wr_data_o); wr_reg.push_back(wr_reg_o); wr_cyc.push_back(cnum);
    end
    if (pwr_en_o === 1'b1) begin
      pwr_dat.push_back(pwr_data_o); pwr_reg.push_back(pwr_o); pwr_ctr.push_back(ctr_o);
    end
    if (done_o === 1'b1) begin
      ndone++; done_cyc = cnum; done_ctr = ctr_o;
    end
  endtask

  task automatic clear_logs();
    wr_dat.delete(); wr_reg.delete(); wr_cyc.delete();
    pwr_dat.delete(); pwr_reg.delete(); pwr_ctr.delete();
    ndone = 0; done_cyc = -1; done_ctr = '0;
  endtask

  task automatic set_op(input sx_alu_op_t op, input logic inv, input logic ci,
                        input sx_cmp_t c, input logic [3:0] ra, input logic avld,
                        input logic [2:0] rq, input logic qvld, input logic pr,
                        input logic [15:0] l, input logic [15:0] r);
    n_op = op; n_inv = inv; n_cin = ci; n_cmp = c; n_a = ra; n_avld = avld;
    n_q = rq; n_qvld = qvld; n_pred = pr; lhs_v = l; rhs_v = r;
  endtask

  // Presents the op until accepted (bounded) and leaves the accept cycle consumed.
  task automatic issue();
    bit got = 1'b0;
    n_vld = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      got = (s_acp === 1'b1);
    end
    n_vld = 1'b0;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL issue_accept: acp never seen within 20 cycles, required 1");
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) cyc();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", s_busy); end
    checks++; if (s_ctr !== 2'd0) begin errors++; $display("FAIL rst_ctr: got %0d want 0", s_ctr); end
    checks++; if (s_wr !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b want 0", s_wr); end
    checks++; if (s_pwr !== 1'b0) begin errors++; $display("FAIL rst_pwr_en: got %b want 0", s_pwr); end
    checks++; if (s_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", s_done); end
    n_rst = 1'b1;
    cyc();
    checks++; if (s_acp !== 1'b1) begin errors++; $display("FAIL rst_idle_acp: got %b want 1", s_acp); end
  endtask

  task automatic test_add();
    logic [3:0] exp_d [4] = '{4'h1, 4'h0, 4'h2, 4'h2};
    int c0;
    clear_logs();
    set_op(SX_ALU_ADD, 1'b0, 1'b0, SX_CMP_EQ, 4'd3, 1'b1, 3'd0, 1'b0, 1'b1, 16'h1234, 16'h0FCD);
    issue();
    c0 = cnum;
    repeat (4) cyc();
    checks++;
    if (wr_dat.size() != 4) begin
      errors++; $display("FAIL add_nwr: got %0d writes want 4", wr_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_dat[i] !== exp_d[i] || wr_reg[i] !== 4'd3 || wr_cyc[i] != c0 + 1 + i) begin
          errors++;
          $display("FAIL add_slice%0d: got r%0d=%h at +%0d want r3=%h at +%0d",
                   i, wr_reg[i], wr_dat[i], wr_cyc[i] - c0, exp_d[i], i + 1);
        end
      end
    end
    checks++; if (ndone != 1 || done_cyc != c0 + 4 || done_ctr !== 2'd3) begin
      errors++; $display("FAIL add_done: got n=%0d at +%0d ctr=%0d want n=1 at +4 ctr=3", ndone, done_cyc - c0, done_ctr);
    end
    checks++; if (pwr_dat.size() != 0) begin errors++; $display("FAIL add_no_pwr: got %0d pwr want 0", pwr_dat.size()); end
    cyc();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL add_idle_after: busy got %b want 0", s_busy); end
  endtask

  task automatic test_logic_flags();
    sx_alu_op_t  lo [5] = '{SX_ALU_ADD, SX_ALU_AND, SX_ALU_OR, SX_ALU_XOR, SX_ALU_XOR};
    logic [15:0] ll [5] = '{16'hFFFF, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'h1234};
    logic [15:0] lr [5] = '{16'h0001, 16'h3C3C, 16'h3C3C, 16'h3C3C, 16'h1234};
    logic [15:0] le [5] = '{16'h0000, 16'h3030, 16'hFCFC, 16'hCCCC, 16'h0000};
    logic        lz [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [15:0] res;
    for (int k = 0; k < 5; k++) begin
      clear_logs();
      set_op(lo[k], 1'b0, 1'b0, SX_CMP_EQ, 4'd8, 1'b1, 3'd6, 1'b1, 1'b1, ll[k], lr[k]);
      issue();
      repeat (4) cyc();
      checks++;
      if (wr_dat.size() != 4) begin
        errors++; $display("FAIL logic%0d_nwr: got %0d writes want 4", k, wr_dat.size());
      end else begin
        res = {wr_dat[3], wr_dat[2], wr_dat[1], wr_dat[0]};
        checks++; if (res !== le[k]) begin errors++; $display("FAIL logic%0d_result: got %h want %h", k, res, le[k]); end
      end
      checks++;
      if (pwr_dat.size() != 1 || pwr_dat[0] !== lz[k] || pwr_reg[0] !== 3'd6) begin
        errors++; $display("FAIL logic%0d_zflag: got n=%0d val=%b want n=1 p6=%b", k, pwr_dat.size(), pwr_dat.size() ? pwr_dat[0] : 1'bx, lz[k]);
      end
    end
  endtask

  task automatic test_compare();
    logic [15:0] cl [12] = '{16'h0005, 16'h0010, 16'hABCD, 16'hABCD, 16'h0005, 16'hABCD,
                             16'hABCD, 16'hFFFF, 16'h8000, 16'h0001, 16'h7FFF, 16'hFFFF};
    logic [15:0] cr [12] = '{16'h0010, 16'h0005, 16'hABCD, 16'h1BCD, 16'h0003, 16'h1BCD,
                             16'hABCD, 16'h0001, 16'h0001, 16'hFFFF, 16'h8000, 16'h0001};
    sx_cmp_t     cc [12] = '{SX_CMP_LTU, SX_CMP_LTU, SX_CMP_EQ, SX_CMP_EQ, SX_CMP_EQ, SX_CMP_NE,
                             SX_CMP_NE, SX_CMP_LT, SX_CMP_LT, SX_CMP_LT, SX_CMP_LT, SX_CMP_LTU};
    logic [2:0]  cq [12] = '{3'd2, 3'd2, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5};
    logic        ce [12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 12; k++) begin
      clear_logs();
      set_op(SX_ALU_CMP, 1'b1, 1'b1, cc[k], 4'd7, 1'b1, cq[k], 1'b1, 1'b1, cl[k], cr[k]);
      issue();
      repeat (4) cyc();
      checks++; if (wr_dat.size() != 0) begin errors++; $display("FAIL cmp%0d_no_gpr: got %0d writes want 0", k, wr_dat.size()); end
      checks++;
      if (pwr_dat.size() != 1) begin
        errors++; $display("FAIL cmp%0d_npwr: got %0d want 1", k, pwr_dat.size());
      end else begin
        checks++;
        if (pwr_dat[0] !== ce[k] || pwr_reg[0] !== cq[k] || pwr_ctr[0] !== 2'd3) begin
          errors++;
          $display("FAIL cmp%0d_result: got p%0d=%b ctr=%0d want p%0d=%b ctr=3",
                   k, pwr_reg[0], pwr_dat[0], pwr_ctr[0], cq[k], ce[k]);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [3:0] exp_d [4] = '{4'hF, 4'hF, 4'h0, 4'h0};
    clear_logs();
    set_op(SX_ALU_ADD, 1'b1, 1'b1, SX_CMP_EQ, 4'd5, 1'b1, 3'd0, 1'b0, 1'b1, 16'h0100, 16'h0001);
    n_stall = 1'b1; n_vld = 1'b1;
    cyc();
    checks++; if (s_acp !== 1'b0) begin errors++; $display("FAIL stall_idle_acp: got %b want 0", s_acp); end
    cyc();
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL stall_idle_busy: got %b want 0", s_busy); end
    n_stall = 1'b0;
    issue();
    repeat (2) cyc();
    n_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (s_ctr !== 2'd2 || s_acp !== 1'b0 || s_wr !== 1'b0 || s_done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold%0d: got ctr=%0d acp=%b wr=%b done=%b want 2/0/0/0", i, s_ctr, s_acp, s_wr, s_done);
      end
    end
    n_stall = 1'b0;
    repeat (2) cyc();
    checks++;
    if (wr_dat.size() != 4) begin
      errors++; $display("FAIL stall_nwr: got %0d writes want 4", wr_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_dat[i] !== exp_d[i] || wr_reg[i] !== 4'd5) begin
          errors++; $display("FAIL stall_slice%0d: got r%0d=%h want r5=%h", i, wr_reg[i], wr_dat[i], exp_d[i]);
        end
      end
    end
    checks++; if (ndone != 1) begin errors++; $display("FAIL stall_done: got %0d want 1", ndone); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_d [4] = '{4'h2, 4'h0, 4'h0, 4'h0};
    int d1;
    clear_logs();
    set_op(SX_ALU_ADD, 1'b0, 1'b0, SX_CMP_EQ, 4'd7, 1'b1, 3'd3, 1'b1, 1'b0, 16'h1111, 16'h2222);
    issue();
    repeat (3) cyc();
    n_op = SX_ALU_ADD; n_a = 4'd4; n_avld = 1'b1; n_qvld = 1'b0; n_pred = 1'b1; n_vld = 1'b1;
    cyc();
    d1 = cnum;
    checks++; if (s_done !== 1'b1 || s_acp !== 1'b1) begin
      errors++; $display("FAIL b2b_overlap: got done=%b acp=%b want 1/1", s_done, s_acp);
    end
    checks++; if (wr_dat.size() != 0 || pwr_dat.size() != 0) begin
      errors++; $display("FAIL b2b_squash: got %0d gpr/%0d pred writes want 0/0", wr_dat.size(), pwr_dat.size());
    end
    n_vld = 1'b0; lhs_v = 16'h0001; rhs_v = 16'h0001;
    repeat (4) cyc();
    checks++;
    if (wr_dat.size() != 4) begin
      errors++; $display("FAIL b2b_nwr: got %0d writes want 4", wr_dat.size());
    end else begin
      checks++; if (wr_cyc[0] != d1 + 1) begin errors++; $display("FAIL b2b_bubble: first write at +%0d want +1", wr_cyc[0] - d1); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_dat[i] !== exp_d[i] || wr_reg[i] !== 4'd4) begin
          errors++; $display("FAIL b2b_slice%0d: got r%0d=%h want r4=%h", i, wr_reg[i], wr_dat[i], exp_d[i]);
        end
      end
    end
    checks++; if (ndone != 2) begin errors++; $display("FAIL b2b_done: got %0d want 2", ndone); end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_d [4] = '{4'h0, 4'h1, 4'h0, 4'h0};
    set_op(SX_ALU_ADD, 1'b0, 1'b0, SX_CMP_EQ, 4'd6, 1'b1, 3'd1, 1'b1, 1'b1, 16'h4444, 16'h1111);
    issue();
    cyc();
    n_rst = 1'b0;
    cyc();
    checks++; if (s_ctr !== 2'd1) begin errors++; $display("FAIL rmid_ctr: got %0d want 1 at reset", s_ctr); end
    clear_logs();
    n_rst = 1'b1;
    set_op(SX_ALU_ADD, 1'b0, 1'b0, SX_CMP_EQ, 4'd9, 1'b1, 3'd0, 1'b0, 1'b1, 16'h000F, 16'h0001);
    n_vld = 1'b1;
    cyc();
    n_vld = 1'b0;
    checks++; if (s_busy !== 1'b0 || s_acp !== 1'b1) begin
      errors++; $display("FAIL rmid_release: got busy=%b acp=%b want 0/1", s_busy, s_acp);
    end
    checks++; if (wr_dat.size() != 0 || pwr_dat.size() != 0 || ndone != 0) begin
      errors++; $display("FAIL rmid_abandon: got %0d/%0d/%0d writes/pwr/done want 0", wr_dat.size(), pwr_dat.size(), ndone);
    end
    repeat (4) cyc();
    checks++;
    if (wr_dat.size() != 4) begin
      errors++; $display("FAIL rmid_nwr: got %0d writes want 4", wr_dat.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wr_dat[i] !== exp_d[i] || wr_reg[i] !== 4'd9) begin
          errors++; $display("FAIL rmid_slice%0d: got r%0d=%h want r9=%h", i, wr_reg[i], wr_dat[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_logs();
    test_reset();
    test_add();
    test_logic_flags();
    test_compare();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
